ram_byte_sequencer: RTL and testbench
=====================================

# ram_byte_sequencer

Load/store sequencer between the RISC-V core's memory stage and the on-chip 1024 x 8 byte RAM. Accepts one 8/16/32-bit load or store per handshake and serialises it into little-endian single-byte RAM accesses. For loads, it sign- or zero-extends the assembled result and returns it with a one-cycle response pulse.

## Interface
- ADDR_WIDTH, 10, byte address width of the RAM
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on edge where valid & ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_signed  in  1  loads: sign-extend when 1
- req_addr  in  ADDR_WIDTH  byte address of least significant byte
- req_wdata  in  32  store data, low bytes used
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores
- rsp_error  out  1  valid with rsp_valid
- ram_address  out  ADDR_WIDTH  to RAM
- ram_data_in  out  8  write byte to RAM
- ram_write_enable  out  1  to RAM
- ram_data_out  in  8  RAM read byte, valid the cycle after its address; not updated during a write

## Operation
- Request fields are latched on accept. Inputs may change afterwards.
- Byte count N: 1, 2, 4 by size.
- Byte k (k = 0..N-1) goes to address req_addr + k, modulo 2^ADDR_WIDTH (wraps 0x3FF -> 0x000).
- Byte k of wdata/rdata is bits [8k+7:8k] (little-endian).
- States:
  - IDLE -> LOAD or STORE on accept.
  - STORE: drive address + byte k with ram_write_enable = 1 for N cycles -> RESP.
  - LOAD: drive address k for N cycles, write_enable = 0. Capture ram_data_out into byte k-1 from the second cycle on -> DRAIN.
  - DRAIN: capture last byte, hold address -> RESP.
  - RESP: rsp_valid = 1 -> IDLE.
- Extension: for N < 4, bits above 8N are filled with bit 8N-1 when req_signed, else 0.
- req_size = 3 is treated as word unless overridden by the Configuration section.
- Reset values: req_ready 1 (IDLE), rsp_valid 0, rsp_rdata 0, rsp_error 0, ram_address 0, ram_data_in 0, ram_write_enable 0, byte counter 0.
- Reset mid-operation: immediate return to IDLE with write_enable deasserted asynchronously. Bytes already written stay written; no response is issued.

## Timing
- Accept edge = E0.
- Store: ram_write_enable high in cycles 1..N; rsp_valid in cycle N+1; req_ready high again in cycle N+2.
- Load: addresses in cycles 1..N; DRAIN in cycle N+1; rsp_valid in cycle N+2.
- Throughput: one request per N+2 (store) / N+3 (load) cycles.
- rsp_valid is registered. A request presented in the RESP cycle is not accepted (req_ready low).

## Configuration
- ALIGN_CHECK_EN defined:
  - These requests are errors: half with addr[0] = 1, word with addr[1:0] != 0, and size = 3.
  - An error request makes no RAM access and never drives write_enable.
  - It goes IDLE -> RESP, so rsp_valid comes in cycle 1 with rsp_error = 1 and rsp_rdata = 0.
- ALIGN_CHECK_EN undefined:
  - Misaligned accesses run bytewise with wrap.
  - rsp_error is tied 0.

## Structure
- Shared package holds:
  - size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - FSM state encodings IDLE/LOAD/STORE/DRAIN/RESP
- Sub-module load_extend (combinational): 32-bit assembled value, size and signed flag in; extended rdata out. Reusable by the peripheral load path.

## Test plan
- SW 0x12345678 @0x010, then LW @0x010:
  - RAM 0x010..0x013 = 78,56,34,12.
  - rdata 0x12345678.
  - Store rsp_valid in cycle 5, load rsp_valid in cycle 6.
- SB 0x80 @0x020, then LB signed @0x020 -> 0xFFFFFF80; LBU -> 0x00000080.
- SH 0xBEEF @0x030, then LH signed -> 0xFFFFBEEF; LHU -> 0x0000BEEF; LB @0x031 -> 0xFFFFFFBE.
- LH @0x3FF after RAM[0x3FF] = 0x34, RAM[0x000] = 0x12:
  - Without macro -> 0x00001234.
  - With ALIGN_CHECK_EN -> rsp_error = 1 in cycle 1, rdata 0, no RAM access.
- SW 0xAABBCCDD @0x040 over zeroed RAM, reset asserted in cycle 3:
  - RAM 0x040 = DD, 0x041 = CC, 0x042..0x043 = 00.
  - No rsp_valid; req_ready = 1 after reset release.
- Back-to-back: req_valid held high with two requests -> second accepted only in the cycle after RESP; inputs changed after accept do not affect the first result.

Source files
------------

// File: rtl/ram_byte_sequencer_pkg.sv
// Shared definitions for the byte RAM load/store sequencer: access size codes,
// FSM state encoding and small decode helpers.
`timescale 1ns/1ps
package ram_byte_sequencer_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STORE = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Index of the last byte of an access (N-1). The reserved size runs as a word.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 2'd0;
      SIZE_HALF: return 2'd1;
      default:   return 2'd3;
    endcase
  endfunction

  // Misaligned half/word, or the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return (addr_lo != 2'd0);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_byte_sequencer_load_extend.sv
// Combinational load extension: keeps the low 8/16/32 bits of an assembled
// value and fills the upper bits with the sign bit or zero.
`timescale 1ns/1ps
module load_extend
  import ram_byte_sequencer_pkg::*;
(
  input  logic [31:0] value,
  input  logic [1:0]  size,
  input  logic        signed_en,
  output logic [31:0] result
);

  // Select width and fill the upper bits.
  always_comb begin
    result = value;
    case (size)
      SIZE_BYTE: result = {{24{signed_en & value[7]}}, value[7:0]};
      SIZE_HALF: result = {{16{signed_en & value[15]}}, value[15:0]};
      default:   result = value;
    endcase
  end

endmodule

// File: rtl/ram_byte_sequencer.sv
// Load/store sequencer between the core memory stage and a byte-wide RAM.
// Each 8/16/32-bit request is split into little-endian single-byte accesses.
// Optional macro ALIGN_CHECK_EN: misaligned half/word and size 3 requests are
// answered immediately with rsp_error and make no RAM access.
//
// Handshake: a request is accepted on the rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE. rsp_valid is a
// single-cycle pulse with no backpressure; rsp_rdata/rsp_error are valid with it.
`timescale 1ns/1ps
module ram_byte_sequencer
  import ram_byte_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]            ram_data_in,
  output logic                  ram_write_enable,
  input  logic [7:0]            ram_data_out,
  output state_t                dbg_state
);

  state_t                state, state_next;
  logic [1:0]            cnt;
  logic [1:0]            last_q;
  logic [1:0]            cap_idx;
  logic                  write_q;
  logic                  signed_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           asm_q;
  logic [31:0]           ext_data;
  logic                  accept;
  logic                  req_err;

  assign accept    = req_valid & (state == IDLE);
  assign last_q    = last_index(size_q);
  // In LOAD the byte arriving now belongs to the previous address; DRAIN takes the last one.
  assign cap_idx   = (state == DRAIN) ? last_q : (cnt - 2'd1);
  assign dbg_state = state;

`ifdef ALIGN_CHECK_EN
  logic err_q;

  assign req_err = is_misaligned(req_size, req_addr[1:0]);

  // Remember whether the accepted request was rejected as misaligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= req_err;
    end
  end
`else
  assign req_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one pass per byte, then (for loads) a drain cycle, then the response.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)        state_next = RESP;
          else if (req_write) state_next = STORE;
          else                state_next = LOAD;
        end
      end
      STORE:   if (cnt == last_q) state_next = RESP;
      LOAD:    if (cnt == last_q) state_next = DRAIN;
      DRAIN:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, byte counter and load data assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 2'd0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      asm_q    <= 32'd0;
    end else if (accept) begin
      cnt      <= 2'd0;
      write_q  <= req_write;
      signed_q <= req_signed;
      size_q   <= req_size;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      asm_q    <= 32'd0;
    end else begin
      case (state)
        STORE: cnt <= (cnt == last_q) ? 2'd0 : cnt + 2'd1;
        LOAD: begin
          if (cnt != 2'd0) asm_q[{cap_idx, 3'b000} +: 8] <= ram_data_out;
          cnt <= (cnt == last_q) ? 2'd0 : cnt + 2'd1;
        end
        DRAIN:   asm_q[{cap_idx, 3'b000} +: 8] <= ram_data_out;
        default: cnt <= cnt;
      endcase
    end
  end

  load_extend u_load_extend (
    .value     (asm_q),
    .size      (size_q),
    .signed_en (signed_q),
    .result    (ext_data)
  );

  // Outputs decoded from state; everything is quiet outside the active phase.
  always_comb begin
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_rdata        = 32'd0;
    rsp_error        = 1'b0;
    ram_address      = '0;
    ram_data_in      = 8'd0;
    ram_write_enable = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      STORE: begin
        ram_address      = addr_q + ADDR_WIDTH'(cnt);
        ram_data_in      = wdata_q[{cnt, 3'b000} +: 8];
        ram_write_enable = 1'b1;
      end
      LOAD:  ram_address = addr_q + ADDR_WIDTH'(cnt);
      DRAIN: ram_address = addr_q + ADDR_WIDTH'(last_q);
      RESP: begin
        rsp_valid = 1'b1;
`ifdef ALIGN_CHECK_EN
        rsp_error = err_q;
        rsp_rdata = (write_q | err_q) ? 32'd0 : ext_data;
`else
        rsp_rdata = write_q ? 32'd0 : ext_data;
`endif
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ram_byte_sequencer.sv
// Directed bench for ram_byte_sequencer with a behavioural byte RAM, a
// response scoreboard and cycle-accurate latency checks. Covers both builds
// (ALIGN_CHECK_EN defined or not).
`timescale 1ns/1ps
module tb_ram_byte_sequencer;
  import ram_byte_sequencer_pkg::*;

  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_write, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_error;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data_in, ram_data_out;
  logic          ram_write_enable;
  state_t        dbg_state;

  ram_byte_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out),
    .dbg_state        (dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [7:0] mem [0:1023] = '{default: 8'h00};
  int wr_count = 0;
  int addr_cycles = 0;

  always @(posedge clk) begin
    if (ram_write_enable) begin
      mem[ram_address] <= ram_data_in;
      wr_count = wr_count + 1;
    end else begin
      ram_data_out <= mem[ram_address];
    end
    if (ram_address != '0) addr_cycles = addr_cycles + 1;
  end

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {error, rdata}

  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[31:0]);
        check("rsp_error", {31'd0, rsp_error}, {31'd0, e[32]});
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one request, scrambles the inputs after accept and checks the
  // number of cycles from the accept edge to rsp_valid.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic err, input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    int guard;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    exp_q.push_back({err, exp_rd});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom_range(0, 1));
    req_size   = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = AW'($urandom_range(0, 1023));
    req_wdata  = $urandom;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w0;
    int a0;
    int rsp_c;
    int rdy_c;
    int lat;

    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  {31'd0, req_ready}, 32'd1);
    check("rst_rspv",   {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata",  rsp_rdata, 32'd0);
    check("rst_err",    {31'd0, rsp_error}, 32'd0);
    check("rst_addr",   32'(ram_address), 32'd0);
    check("rst_din",    32'(ram_data_in), 32'd0);
    check("rst_we",     {31'd0, ram_write_enable}, 32'd0);
    check("rst_state",  32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Word store then load
    w0 = wr_count;
    do_req("sw", 1'b1, SIZE_WORD, 1'b0, 10'h010, 32'h12345678, 1'b0, 32'd0, 5);
    check("sw_mem10", 32'(mem[10'h010]), 32'h78);
    check("sw_mem11", 32'(mem[10'h011]), 32'h56);
    check("sw_mem12", 32'(mem[10'h012]), 32'h34);
    check("sw_mem13", 32'(mem[10'h013]), 32'h12);
    check("sw_wrcnt", 32'(wr_count - w0), 32'd4);
    do_req("lw", 1'b0, SIZE_WORD, 1'b0, 10'h010, 32'd0, 1'b0, 32'h12345678, 6);

    // Byte store / loads
    do_req("sb", 1'b1, SIZE_BYTE, 1'b0, 10'h020, 32'h11223380, 1'b0, 32'd0, 2);
    check("sb_mem20", 32'(mem[10'h020]), 32'h80);
    check("sb_mem21", 32'(mem[10'h021]), 32'h00);
    do_req("lb",  1'b0, SIZE_BYTE, 1'b1, 10'h020, 32'd0, 1'b0, 32'hFFFFFF80, 3);
    do_req("lbu", 1'b0, SIZE_BYTE, 1'b0, 10'h020, 32'd0, 1'b0, 32'h00000080, 3);

    // Half store / loads
    do_req("sh", 1'b1, SIZE_HALF, 1'b0, 10'h030, 32'h5555BEEF, 1'b0, 32'd0, 3);
    check("sh_mem30", 32'(mem[10'h030]), 32'hEF);
    check("sh_mem31", 32'(mem[10'h031]), 32'hBE);
    check("sh_mem32", 32'(mem[10'h032]), 32'h00);
    do_req("lh",     1'b0, SIZE_HALF, 1'b1, 10'h030, 32'd0, 1'b0, 32'hFFFFBEEF, 4);
    do_req("lhu",    1'b0, SIZE_HALF, 1'b0, 10'h030, 32'd0, 1'b0, 32'h0000BEEF, 4);
    do_req("lb_031", 1'b0, SIZE_BYTE, 1'b1, 10'h031, 32'd0, 1'b0, 32'hFFFFFFBE, 3);

    // Wrap-around half load at the top of the RAM
    do_req("sb_3ff", 1'b1, SIZE_BYTE, 1'b0, 10'h3FF, 32'h00000034, 1'b0, 32'd0, 2);
    do_req("sb_000", 1'b1, SIZE_BYTE, 1'b0, 10'h000, 32'h00000012, 1'b0, 32'd0, 2);
    check("wrap_mem3ff", 32'(mem[10'h3FF]), 32'h34);
    check("wrap_mem000", 32'(mem[10'h000]), 32'h12);
`ifdef ALIGN_CHECK_EN
    w0 = wr_count;
    a0 = addr_cycles;
    do_req("lh_wrap", 1'b0, SIZE_HALF, 1'b0, 10'h3FF, 32'd0, 1'b1, 32'd0, 1);
    check("lh_wrap_nowr",   32'(wr_count - w0), 32'd0);
    check("lh_wrap_noaddr", 32'(addr_cycles - a0), 32'd0);
    w0 = wr_count;
    do_req("sw_mis", 1'b1, SIZE_WORD, 1'b0, 10'h041, 32'hFFFFFFFF, 1'b1, 32'd0, 1);
    check("sw_mis_nowr",  32'(wr_count - w0), 32'd0);
    check("sw_mis_mem41", 32'(mem[10'h041]), 32'h00);
    do_req("size3", 1'b0, SIZE_RSVD, 1'b0, 10'h010, 32'd0, 1'b1, 32'd0, 1);
`else
    do_req("lh_wrap", 1'b0, SIZE_HALF, 1'b0, 10'h3FF, 32'd0, 1'b0, 32'h00001234, 4);
    do_req("size3",   1'b0, SIZE_RSVD, 1'b0, 10'h010, 32'd0, 1'b0, 32'h12345678, 6);
`endif

    // Reset during a word store: two bytes land, no response
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = 10'h040; req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_we",    {31'd0, ram_write_enable}, 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem40", 32'(mem[10'h040]), 32'hDD);
    check("rst_mem41", 32'(mem[10'h041]), 32'hCC);
    check("rst_mem42", 32'(mem[10'h042]), 32'h00);
    check("rst_mem43", 32'(mem[10'h043]), 32'h00);

    // Back-to-back with req_valid held high; inputs switch to the second request after accept
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = 10'h010; req_wdata = 32'd0;
    exp_q.push_back({1'b0, 32'h12345678});
    exp_q.push_back({1'b0, 32'hFFFFFF80});
    @(posedge clk);
    #1;
    req_size = SIZE_BYTE; req_signed = 1'b1; req_addr = 10'h020;
    rsp_c = 0;
    rdy_c = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_c = c;
        check("b2b_ready_in_resp", {31'd0, req_ready}, 32'd0);
      end
      if (req_ready) begin
        rdy_c = c;
        break;
      end
    end
    check("b2b_rsp_cycle",   32'(rsp_c), 32'd6);
    check("b2b_ready_cycle", 32'(rdy_c), 32'd7);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    check("b2b_second_lat", 32'(lat), 32'd3);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
